// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32I 5-stage core.
// Contents:
//   exmem_t     - EX/MEM register bundle consumed by mem_stage
//   memwb_t     - MEM/WB register bundle read by the writeback stage
//   mem_state_t - data-memory transaction state
//   F3_*        - funct3 encodings for loads and stores
package pipeline_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] ALUResult;
        logic [31:0] WriteData;
        logic [4:0]  Rd;
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic        MemRead;
        logic [2:0]  funct3;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ALUResult;
        logic [31:0] load_data;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
        logic [4:0]  Rd;
        logic        RegWrite;
        logic [1:0]  ResultSrc;
    } memwb_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane formatting for the memory stage (purely combinational).
// Ports:
//   funct3     in  access size / signedness
//   addr_lo    in  byte offset within the word (ALUResult[1:0])
//   store      in  1 for a store, 0 for a load
//   write_data in  register value to be stored
//   rdata      in  raw word returned by data memory
//   be         out byte enables (all ones for loads)
//   wdata      out store data replicated into every lane
//   load_data  out extracted and sign/zero-extended load value
//   aligned    out 1 when the access fits its natural alignment
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        store,
    input  logic [31:0] write_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        aligned
);

    logic [7:0]  rbyte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lanes of the read word, and store data replicated per lane so the
    // byte enables alone pick which lane memory actually writes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rbyte[gi] = rdata[8*gi +: 8];
        assign wdata[8*gi +: 8] = (funct3[1:0] == 2'b00) ? write_data[7:0] :
                                  (funct3[1:0] == 2'b01) ? write_data[8*(gi%2) +: 8] :
                                                           write_data[8*gi +: 8];
    end

    assign byte_sel = rbyte[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        aligned   = 1'b1;
        be        = 4'b1111;
        load_data = rdata;

        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_lo[0];
            default: aligned = (addr_lo == 2'b00);
        endcase

        if (store) begin
            case (funct3[1:0])
                2'b00:   be = 4'b0001 << addr_lo;
                2'b01:   be = 4'b0011 << addr_lo;
                default: be = 4'b1111;
            endcase
        end

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives loads/stores onto a single-outstanding
// req/gnt/rvalid bus, stalls the front of the pipe while a transaction is in
// flight, and owns the MEM/WB register.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   inputs               EX/MEM bundle (held by the pipe while stall_mem=1)
//   outputs              registered MEM/WB bundle
//   stall_mem            freeze IF/ID/EX and hold EX/MEM
//   misaligned           one-cycle pulse after a misaligned access
//   mem_fault            one-cycle pulse after a bus timeout
//   dmem_*               data-memory request / response bus
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  exmem_t      inputs,
    output memwb_t      outputs,
    output logic        stall_mem,
    output logic        misaligned,
    output logic        mem_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    mem_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             misaligned_reg;
    logic             mem_fault_reg;
    memwb_t           outputs_reg;

    logic        aligned;
    logic [31:0] ext_data;
    logic        is_access, is_load, is_store, mem_op, misalign_now;
    logic        req_next, done_next, timed_out_next, rsp_ok_next;

    assign is_access    = inputs.valid & (inputs.MemRead | inputs.MemWrite);
    assign is_load      = inputs.MemRead;
    assign is_store     = inputs.MemWrite & ~inputs.MemRead;
    assign mem_op       = is_access & aligned;
    assign misalign_now = is_access & ~aligned;

    lsu_align u_align (
        .funct3     (inputs.funct3),
        .addr_lo    (inputs.ALUResult[1:0]),
        .store      (is_store),
        .write_data (inputs.WriteData),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (ext_data),
        .aligned    (aligned)
    );

    assign dmem_addr = {inputs.ALUResult[31:2], 2'b00};
    assign dmem_we   = is_store;

    // rvalid is only looked at in WAIT_RSP: a response coinciding with gnt,
    // or arriving after a timeout, is dropped.
    always_comb begin
        req_next       = 1'b0;
        done_next      = 1'b0;
        timed_out_next = 1'b0;
        rsp_ok_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_next  = mem_op;
                done_next = mem_op & dmem_gnt & is_store;
            end
            REQ: begin
                req_next       = 1'b1;
                done_next      = dmem_gnt & is_store;
                timed_out_next = TO_EN & ~dmem_gnt & (cnt_reg == TO_LAST);
            end
            WAIT_RSP: begin
                rsp_ok_next    = dmem_rvalid;
                done_next      = dmem_rvalid;
                timed_out_next = TO_EN & ~dmem_rvalid & (cnt_reg == TO_LAST);
            end
            default: ;
        endcase
        done_next = done_next | timed_out_next;
    end

    // Gating with rst_n drops the request and stall during the reset cycle
    // itself, not one cycle later.
    assign dmem_req  = rst_n & req_next;
    assign stall_mem = rst_n & mem_op & ~done_next;

    // The counter restarts whenever a waiting state is entered; the timeout
    // fires on the TIMEOUT_CYCLES-th cycle spent waiting in REQ or WAIT_RSP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            misaligned_reg <= 1'b0;
            mem_fault_reg  <= 1'b0;
            outputs_reg    <= '0;
        end else begin
            misaligned_reg <= misalign_now;
            mem_fault_reg  <= timed_out_next;

            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        cnt_reg <= '0;
                        if (!dmem_gnt)
                            state_reg <= REQ;
                        else if (is_load)
                            state_reg <= WAIT_RSP;
                    end
                end
                REQ: begin
                    if (timed_out_next) begin
                        state_reg <= IDLE;
                    end else if (dmem_gnt) begin
                        cnt_reg   <= '0;
                        state_reg <= is_load ? WAIT_RSP : IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rvalid || timed_out_next)
                        state_reg <= IDLE;
                    else
                        cnt_reg <= cnt_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase

            // A stalled cycle writes a bubble so writeback sees each
            // instruction exactly once, on the cycle it completes.
            if (stall_mem) begin
                outputs_reg <= '0;
            end else begin
                outputs_reg.valid     <= inputs.valid;
                outputs_reg.ALUResult <= inputs.ALUResult;
                outputs_reg.load_data <= rsp_ok_next ? ext_data : 32'h0;
                outputs_reg.PCPlus4   <= inputs.PCPlus4;
                outputs_reg.ImmExt    <= inputs.ImmExt;
                outputs_reg.Rd        <= inputs.Rd;
                outputs_reg.RegWrite  <= inputs.valid & inputs.RegWrite &
                                         ~misalign_now & ~timed_out_next;
                outputs_reg.ResultSrc <= inputs.ResultSrc;
            end
        end
    end

    assign outputs    = outputs_reg;
    assign misaligned = misaligned_reg;
    assign mem_fault  = mem_fault_reg;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the RV32I 5-stage pipeline, between the EX/MEM register and the WB stage.
- Consumes an exmem_t bundle and drives loads and stores onto a single-outstanding req/gnt/rvalid data-memory bus.
- Aligns and sign/zero-extends load data, generates store byte-enables, and owns the MEM/WB pipeline register (memwb_t) that the writeback stage reads.
- Raises a stall to the hazard unit while a memory transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles waiting for gnt or rvalid before mem_fault; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- inputs  in  exmem_t  EX/MEM bundle: valid, ALUResult, WriteData, Rd, RegWrite, ResultSrc[1:0], MemWrite, MemRead, funct3, PCPlus4, ImmExt.
- outputs  out  memwb_t  registered MEM/WB bundle: valid, ALUResult, load_data, PCPlus4, ImmExt, Rd, RegWrite, ResultSrc.
- stall_mem  out  1  freeze IF/ID/EX and hold the EX/MEM register.
- misaligned  out  1  registered, one-cycle pulse per misaligned access.
- mem_fault  out  1  registered, one-cycle pulse when a transaction times out.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write when 1.
- dmem_addr  out  32  word-aligned address, {ALUResult[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  store data, lane-shifted.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - FSM returns to IDLE; timeout counter cleared.
  - outputs cleared to all-zero, so valid=0 and RegWrite=0.
  - stall_mem, misaligned, mem_fault, dmem_req are 0.
- Memory operation: mem_op = inputs.valid & (MemRead | MemWrite) & aligned.
- Alignment rules:
  - Word (funct3[1:0]=10) requires addr[1:0]=00.
  - Half (01) requires addr[0]=0.
  - Byte is always aligned.
- Misaligned access:
  - No bus request is issued.
  - misaligned pulses in the next cycle.
  - outputs gets that instruction with RegWrite=0.
  - No stall.
- FSM states and transitions:
  - IDLE: dmem_req=mem_op, driven combinationally.
    - gnt & store: done, stay in IDLE.
    - gnt & load: go to WAIT_RSP.
    - no gnt: go to REQ.
  - REQ: dmem_req=1, with address, we, be and wdata held stable.
    - gnt: store done, go to IDLE; load goes to WAIT_RSP.
  - WAIT_RSP: dmem_req=0.
    - rvalid: load done, go to IDLE.
- stall_mem = mem_op & ~done_this_cycle.
- rvalid arriving in the same cycle as gnt: ignored. The response is only accepted in WAIT_RSP.
- Minimum latencies:
  - A store granted in the same cycle has no stall.
  - A load has at least 1 stall cycle.
- MEM/WB register update:
  - Non-stalled cycle: outputs <= inputs fields plus load_data.
  - Stalled cycle: outputs <= bubble (valid=0, RegWrite=0). Writeback never sees a duplicate.
- Load extraction (from dmem_rdata and addr[1:0]):
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half lane addr[1], sign- or zero-extended.
  - LW: passed through.
  - load_data for non-loads is 0.
- Store formatting:
  - SB: be = 0001<<addr[1:0]; wdata = {4{WriteData[7:0]}}.
  - SH: be = 0011<<addr[1:0]; wdata = {2{WriteData[15:0]}}.
  - SW: be = 1111; wdata = WriteData.
  - Loads: be = 1111.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entering REQ or WAIT_RSP and increments each waiting cycle.
  - On reaching TIMEOUT_CYCLES: return to IDLE, pulse mem_fault, complete the instruction with RegWrite=0, release the stall.
  - A late rvalid or gnt after a timeout is ignored while in IDLE.
- Reset mid-transaction: FSM returns to IDLE; req drops in the same edge; no memwb write.
- Invalid input (inputs.valid=0) produces a bubble with no request.

Decomposition:
- pipeline_pkg gains:
  - exmem_t typedef, with MemRead and funct3 fields added.
  - mem_state_t enum {IDLE, REQ, WAIT_RSP}.
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- memwb_t is reused unchanged.
- One sub-module: lsu_align. It is purely combinational and produces be, wdata, load_data and the aligned flag from funct3, addr[1:0], WriteData and rdata.
- The FSM, timeout counter and MEM/WB register stay in mem_stage.

Test Plan:
- ALU op (RegWrite=1, Rd=5, ALUResult=0x1234) -> no req; next cycle outputs.valid=1, Rd=5, ALUResult=0x1234; stall_mem=0 throughout.
- SB to 0x1003 with WriteData=0xAB, gnt same cycle -> req=1, be=1000, wdata=0xABABABAB, addr=0x1000; no stall.
- LH to 0x2002 with rdata=0x8001_0000, gnt cycle 0, rvalid cycle 2 -> stall_mem=1 in cycles 0–1 with a bubble into memwb; cycle-2 edge gives load_data=0xFFFF8001. LHU of the same access gives 0x00008001.
- LW to 0x3001 -> no req; misaligned pulses one cycle; outputs.RegWrite=0.
- TIMEOUT_CYCLES=4, load with gnt withheld -> mem_fault pulses after 4 waiting cycles; stall drops; a subsequent rvalid is ignored.
- rst_n=0 while in WAIT_RSP -> next edge gives req=0, stall=0, outputs.valid=0, state IDLE.
